// File: rtl/q_display_mux.sv
// Shows the 6-bit counter value as two decimal digits on a multiplexed 7-segment display.
// A sequential shift-add-3 engine does the binary-to-BCD conversion; a prescaled scan drives the digits.
module q_display_mux #(
    parameter int F_CLK_HZ           = 25_000_000,
    parameter int SCAN_HZ            = 1000,
    parameter bit SEG_ACTIVE_LOW     = 1'b1,
    parameter bit DIG_ACTIVE_LOW     = 1'b1,
    parameter bit BLANK_LEADING_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] value,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic [2:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       conv_busy
);

    localparam int PRESC_RAW = F_CLK_HZ / SCAN_HZ;
    localparam int PRESC     = (PRESC_RAW < 2) ? 2 : PRESC_RAW;
    localparam int SCAN_W    = $clog2(PRESC);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(PRESC - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [5:0]        value_r;
    logic [5:0]        snap_r;
    logic [5:0]        last_conv_r;
    logic [12:0]       shreg_r;
    logic [2:0]        iter_r;
    logic              force_r;
    logic [2:0]        bcd_tens_r;
    logic [3:0]        bcd_ones_r;
    logic              busy_r;
    logic [SCAN_W-1:0] scan_cnt_r;
    logic              digit_sel_r;
    logic [6:0]        seg_r;
    logic [1:0]        dig_r;
    logic [6:0]        seg_on_s;
    logic [1:0]        en_s;
    logic [3:0]        code_s;

    // One combined double-dabble step: correct both BCD fields, then shift left.
    function automatic logic [12:0] dabble_step(input logic [12:0] sr);
        logic [12:0] adj;
        adj = sr;
        if (sr[9:6] >= 4'd5) adj[9:6] = sr[9:6] + 4'd3;
        else                 adj[9:6] = sr[9:6];
        if (sr[12:10] >= 3'd5) adj[12:10] = sr[12:10] + 3'd3;
        else                   adj[12:10] = sr[12:10];
        return {adj[11:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Converter next-state logic; a value change mid-run is picked up on return to IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (force_r || (value_r != last_conv_r)) state_s = ST_LOAD;
                else                                      state_s = ST_IDLE;
            end
            ST_LOAD:  state_s = ST_SHIFT;
            ST_SHIFT: begin
                if (iter_r == 3'd5) state_s = ST_COMMIT;
                else                state_s = ST_SHIFT;
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Converter state, datapath and committed BCD result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            value_r     <= 6'd0;
            snap_r      <= 6'd0;
            last_conv_r <= 6'd0;
            shreg_r     <= 13'd0;
            iter_r      <= 3'd0;
            force_r     <= 1'b1;
            bcd_tens_r  <= 3'd0;
            bcd_ones_r  <= 4'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            value_r <= value;
            busy_r  <= (state_s != ST_IDLE);
            case (state_r)
                ST_LOAD: begin
                    shreg_r <= {7'd0, value_r};
                    snap_r  <= value_r;
                    iter_r  <= 3'd0;
                    force_r <= 1'b0;
                end
                ST_SHIFT: begin
                    shreg_r <= dabble_step(shreg_r);
                    iter_r  <= iter_r + 3'd1;
                end
                ST_COMMIT: begin
                    bcd_tens_r  <= shreg_r[12:10];
                    bcd_ones_r  <= shreg_r[9:6];
                    last_conv_r <= snap_r;
                end
                default: begin
                    shreg_r <= shreg_r;
                end
            endcase
        end
    end

    // Scan prescaler; the active digit flips on the blanking cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_r  <= '0;
            digit_sel_r <= 1'b0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r  <= '0;
            digit_sel_r <= ~digit_sel_r;
        end else begin
            scan_cnt_r  <= scan_cnt_r + SCAN_ONE;
            digit_sel_r <= digit_sel_r;
        end
    end

    // Select and decode the active digit, with ghosting blank and leading-zero suppression.
    always_comb begin
        code_s   = digit_sel_r ? {1'b0, bcd_tens_r} : bcd_ones_r;
        seg_on_s = 7'h00;
        en_s     = 2'b00;
        if (scan_cnt_r == SCAN_LAST) begin
            seg_on_s = 7'h00;
            en_s     = 2'b00;
        end else if (digit_sel_r) begin
            if (BLANK_LEADING_ZERO && (bcd_tens_r == 3'd0)) begin
                seg_on_s = 7'h00;
                en_s     = 2'b00;
            end else begin
                seg_on_s = seg_decode(code_s);
                en_s     = 2'b10;
            end
        end else begin
            seg_on_s = seg_decode(code_s);
            en_s     = 2'b01;
        end
    end

    // Registered pin drive with polarity applied; reset leaves everything dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_r <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
            dig_r <= DIG_ACTIVE_LOW ? 2'b11 : 2'b00;
        end else begin
            seg_r <= SEG_ACTIVE_LOW ? ~seg_on_s : seg_on_s;
            dig_r <= DIG_ACTIVE_LOW ? ~en_s : en_s;
        end
    end

    assign seg       = seg_r;
    assign dig       = dig_r;
    assign bcd_tens  = bcd_tens_r;
    assign bcd_ones  = bcd_ones_r;
    assign conv_busy = busy_r;

endmodule

// File: tb/tb_q_display_mux.sv
// Randomized self-checking bench for q_display_mux (PRESC=4, active-low pins, leading-zero blanking).
module tb_q_display_mux;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] value;
    logic [6:0] seg;
    logic [1:0] dig;
    logic [2:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       conv_busy;

    int checks   = 0;
    int failures = 0;
    int edges;

    always #5 clk = ~clk;

    q_display_mux #(
        .F_CLK_HZ(1000),
        .SCAN_HZ(250),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1),
        .BLANK_LEADING_ZERO(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .value(value),
        .seg(seg),
        .dig(dig),
        .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones),
        .conv_busy(conv_busy)
    );

    // Clock edges since reset release: the scan position is a pure function of this count.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string tag,
                             output int n, output bit ok);
        n  = 0;
        ok = 1'b1;
        while (conv_busy !== lvl && n < budget) begin
            tick();
            n++;
        end
        if (conv_busy !== lvl) begin
            ok = 1'b0;
            checks++;
            failures++;
            $display("FAIL %s_timeout conv_busy=%b required=%b", tag, conv_busy, lvl);
        end
    endtask

    // Drive v, wait for one conversion, check busy length and the decimal digits.
    task automatic convert_check(input logic [5:0] v, input string tag);
        int n;
        bit ok;
        value = v;
        wait_busy(1'b1, 10, tag, n, ok);
        if (!ok) return;
        wait_busy(1'b0, 30, tag, n, ok);
        if (!ok) return;
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL %s_busy_len got=%0d required=8", tag, n);
        end
        checks++;
        if (bcd_tens !== 3'(v / 10) || bcd_ones !== 4'(v % 10)) begin
            failures++;
            $display("FAIL %s_bcd v=%0d got=%0d/%0d required=%0d/%0d",
                     tag, v, bcd_tens, bcd_ones, v / 10, v % 10);
        end
        checks++;
        if (bcd_ones > 4'd9) begin
            failures++;
            $display("FAIL %s_ones_range got=%0d required<=9", tag, bcd_ones);
        end
    endtask

    // Compare dig/seg against the scan schedule for a stable displayed value.
    task automatic check_display(input int v, input int cycles, input string tag);
        int s, tens, ones, units_on, tens_on, off;
        logic [1:0] exp_dig;
        logic [6:0] exp_seg;
        bit seg_valid;
        tens = v / 10;
        ones = v % 10;
        units_on = 0; tens_on = 0; off = 0;
        tick();
        for (int i = 0; i < cycles; i++) begin
            tick();
            s = edges - 1;
            seg_valid = 1'b1;
            if (s % 4 == 3) begin
                exp_dig = 2'b11; exp_seg = 7'h7F; seg_valid = 1'b0;
            end else if ((s / 4) % 2 == 0) begin
                exp_dig = 2'b10; exp_seg = ~seg_of(ones);
            end else if (tens == 0) begin
                exp_dig = 2'b11; exp_seg = 7'h7F;
            end else begin
                exp_dig = 2'b01; exp_seg = ~seg_of(tens);
            end
            checks++;
            if (dig !== exp_dig || (seg_valid && seg !== exp_seg)) begin
                failures++;
                $display("FAIL %s_scan cyc=%0d dig=%b seg=%h required dig=%b seg=%h",
                         tag, i, dig, seg, exp_dig, exp_seg);
            end
            if (i < 8) begin
                if (dig === 2'b10) units_on++;
                else if (dig === 2'b01) tens_on++;
                else off++;
            end
        end
        if (tens != 0 && cycles >= 8) begin
            checks++;
            if (units_on != 3 || tens_on != 3 || off != 2) begin
                failures++;
                $display("FAIL %s_duty units=%0d tens=%0d off=%0d required 3/3/2",
                         tag, units_on, tens_on, off);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        bit ok;
        reset_n = 1'b0;
        value   = 6'd0;
        repeat (3) tick();
        checks++;
        if (seg !== 7'h7F || dig !== 2'b11 || conv_busy !== 1'b0 ||
            bcd_tens !== 3'd0 || bcd_ones !== 4'd0) begin
            failures++;
            $display("FAIL reset_state seg=%h dig=%b busy=%b bcd=%0d/%0d required 7f/11/0/0/0",
                     seg, dig, conv_busy, bcd_tens, bcd_ones);
        end
        reset_n = 1'b1;
        wait_busy(1'b1, 10, "reset_force", n, ok);
        if (!ok) return;
        wait_busy(1'b0, 30, "reset_force", n, ok);
        if (!ok) return;
        checks++;
        if (n !== 8 || bcd_tens !== 3'd0 || bcd_ones !== 4'd0) begin
            failures++;
            $display("FAIL reset_force len=%0d bcd=%0d/%0d required 8 0/0", n, bcd_tens, bcd_ones);
        end
        check_display(0, 16, "zero");
    endtask

    task automatic test_max();
        convert_check(6'd63, "max");
        check_display(63, 16, "max");
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 64; v++) convert_check(6'(v), "sweep");
    endtask

    task automatic test_change_midrun();
        int n;
        bit ok;
        logic [6:0] prev;
        logic [6:0] seen[$];
        prev  = {bcd_tens, bcd_ones};
        value = 6'd10;
        wait_busy(1'b1, 10, "midrun", n, ok);
        if (!ok) return;
        repeat (3) tick();
        value = 6'd20;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ({bcd_tens, bcd_ones} !== prev) begin
                prev = {bcd_tens, bcd_ones};
                seen.push_back(prev);
            end
        end
        checks++;
        if (seen.size() != 2 || seen[0] !== {3'd1, 4'd0} || seen[1] !== {3'd2, 4'd0}) begin
            failures++;
            $display("FAIL midrun_sequence updates=%0d first=%h last=%h required 2 updates 10 then 20",
                     seen.size(), (seen.size() > 0) ? seen[0] : 7'h7F,
                     (seen.size() > 0) ? seen[seen.size()-1] : 7'h7F);
        end
        checks++;
        if (conv_busy !== 1'b0) begin
            failures++;
            $display("FAIL midrun_idle busy=%b required=0", conv_busy);
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        bit ok;
        value = 6'd45;
        wait_busy(1'b1, 10, "rst_mid", n, ok);
        if (!ok) return;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (bcd_tens !== 3'd0 || bcd_ones !== 4'd0 || conv_busy !== 1'b0 ||
            dig !== 2'b11 || seg !== 7'h7F) begin
            failures++;
            $display("FAIL rst_mid_clear bcd=%0d/%0d busy=%b dig=%b seg=%h required 0/0 0 11 7f",
                     bcd_tens, bcd_ones, conv_busy, dig, seg);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        convert_check(6'd45, "rst_mid");
        check_display(45, 16, "rst_mid");
    endtask

    task automatic test_random();
        logic [5:0] last;
        logic [5:0] v;
        last = 6'd45;
        for (int i = 0; i < 16; i++) begin
            v = 6'($urandom_range(0, 63));
            if (v == last) v = v + 6'd1;
            convert_check(v, "random");
            if (i % 4 == 0) check_display(int'(v), 8, "random");
            last = v;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        value   = 6'd0;
        test_reset();
        test_max();
        test_sweep();
        test_change_midrun();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
